// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared front-end types: opcodes, fetch FSM states, IF/ID entry
package core_types_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcodes_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t EMPTY_ENTRY = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with a one-entry skid buffer
module if_id_reg
  import core_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        load_fetch,
  input  logic        load_skid,
  input  logic        skid_to_id,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  if_id_t id_q, id_d;
  if_id_t skid_q, skid_d;

  always_comb begin
    id_d   = id_q;
    skid_d = skid_q;
    if (flush) begin
      id_d.valid   = 1'b0;
      skid_d.valid = 1'b0;
    end else begin
      if (load_fetch) begin
        id_d = '{valid: 1'b1, pc: fetch_pc, instr: fetch_instr};
      end else if (skid_to_id) begin
        id_d         = skid_q;
        id_d.valid   = 1'b1;
        skid_d.valid = 1'b0;
      end else if (!stall) begin
        // downstream took the entry and nothing replaces it
        id_d.valid = 1'b0;
      end
      if (load_skid) begin
        skid_d = '{valid: 1'b1, pc: fetch_pc, instr: fetch_instr};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q   <= EMPTY_ENTRY;
      skid_q <= EMPTY_ENTRY;
    end else begin
      id_q   <= id_d;
      skid_q <= skid_d;
    end
  end

  assign id_valid = id_q.valid;
  assign id_pc    = id_q.pc;
  assign id_instr = id_q.instr;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM and pc; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect fault
module fetch_stage
  import core_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output opcodes_t    opcode,
  output logic [2:0]  func3,
  output logic        f7,
  output logic [24:0] immSample,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         req_fire;
  logic         flush;
  logic         load_fetch;
  logic         load_skid;
  logic         skid_to_id;
  logic [31:0]  redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc;
`else
  logic unused_redirect_low;
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    req_fire   = 1'b0;
    flush      = 1'b0;
    load_fetch = 1'b0;
    load_skid  = 1'b0;
    skid_to_id = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d = |redirect_pc[1:0];
`endif
      // an in-flight response still owed by memory must be swallowed first
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (!fault_q) begin
            req_fire = 1'b1;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_d = pc_q + 32'd4;
            if (stall && id_valid) begin
              load_skid = 1'b1;
              state_d   = S_HOLD;
            end else begin
              load_fetch = 1'b1;
              state_d    = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            skid_to_id = 1'b1;
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req  = req_fire & rst_n;
  assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .load_fetch  (load_fetch),
    .load_skid   (load_skid),
    .skid_to_id  (skid_to_id),
    .fetch_pc    (pc_q),
    .fetch_instr (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  assign opcode    = opcodes_t'(id_instr[6:0]);
  assign func3     = id_instr[14:12];
  assign f7        = id_instr[30];
  assign immSample = id_instr[31:7];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (requests and consumed IF/ID entries)
`timescale 1ns/1ps
module tb_fetch_stage;
  import core_types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  opcodes_t    opcode;
  logic [2:0]  func3;
  logic        f7;
  logic [24:0] imm_sample;
  logic        fetch_fault;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_instr;
  opcodes_t    w_opcode;
  logic [2:0]  w_func3;
  logic        w_f7;
  logic [24:0] w_imm;
  logic        w_fault;

  int checks_total;
  int checks_pass;

  logic [31:0] exp_req[$];
  logic [63:0] exp_id[$];
  logic [31:0] w_seen[$];

  bit          mem_gate;
  bit          pend;
  logic [31:0] pend_addr;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .opcode(opcode),
    .func3(func3), .f7(f7), .immSample(imm_sample), .fetch_fault(fetch_fault)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_id_valid), .id_pc(w_id_pc), .id_instr(w_id_instr), .opcode(w_opcode),
    .func3(w_func3), .f7(w_f7), .immSample(w_imm), .fetch_fault(w_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a << 5) ^ 32'h1234_5673 ^ {a[9:2], 24'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [31:0] pc);
    exp_id.push_back({pc, instr_of(pc)});
  endtask

  // memory with one-cycle latency; mem_gate=0 freezes the pending response
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend        = 1'b0;
    pend_addr   = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
      end
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (pend && mem_gate) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend_addr);
        pend        = 1'b0;
      end
    end
  end

  initial begin
    logic        wp;
    logic [31:0] wa;
    w_rvalid = 1'b0;
    w_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      wp = rst_n && w_req;
      wa = w_addr;
      if (wp && w_seen.size() < 2) w_seen.push_back(w_addr);
      @(posedge clk);
      #2;
      w_rvalid = wp;
      w_rdata  = instr_of(wa);
    end
  end

  // monitor: every request and every consumed IF/ID entry pops the scoreboard
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req) begin
        if (exp_req.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_req.pop_front());
        end
      end
      if (rst_n && id_valid && !stall) begin
        if (exp_id.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_id: got pc %h instr %h expected no entry", id_pc, id_instr);
        end else begin
          e = exp_id.pop_front();
          check("id_pc", id_pc, e[63:32]);
          check("id_instr", id_instr, e[31:0]);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    #3;
    check({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
    check({tag, "_id_pc"}, id_pc, 32'h0);
    check({tag, "_id_instr"}, id_instr, NOP_INSTR);
    check({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
    check({tag, "_opcode"}, {25'h0, opcode}, 32'h13);
  endtask

  // entered in S_WAIT with a frozen response; ends the same way
  task automatic redirect_flow(input logic [31:0] target, input logic [31:0] exp_pc);
    exp_req.push_back(exp_pc);
    exp_req.push_back(exp_pc + 32'd4);
    push_id(exp_pc);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    mem_gate       = 1'b1;
    #3;
    check("redir_flush_valid", {31'h0, id_valid}, 32'h0);
    tick();
    tick();
    tick();
    mem_gate = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    logic [31:0] e;
    checks_total   = 0;
    checks_pass    = 0;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_gate       = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");

    // sequential fetch, 1-cycle memory
    tick();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    push_id(32'h0);
    push_id(32'h4);
    push_id(32'h8);
    rst_n    = 1'b1;
    mem_gate = 1'b1;
    #3;
    check("first_req_after_reset", {31'h0, imem_req}, 32'h1);
    repeat (6) tick();
    mem_gate = 1'b0;
    repeat (3) tick();

    // stall with a live entry while a response lands in the skid buffer
    exp_req.push_back(32'h10);
    exp_req.push_back(32'h14);
    push_id(32'hC);
    push_id(32'h10);
    stall    = 1'b1;
    mem_gate = 1'b1;
    repeat (3) tick();
    e = instr_of(32'hC);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("stall_id_valid", {31'h0, id_valid}, 32'h1);
      check("stall_id_pc", id_pc, 32'hC);
      check("stall_id_instr", id_instr, e);
      check("stall_no_req", {31'h0, imem_req}, 32'h0);
      check("stall_opcode", {25'h0, opcode}, {25'h0, e[6:0]});
      check("stall_func3", {29'h0, func3}, {29'h0, e[14:12]});
      check("stall_f7", {31'h0, f7}, {31'h0, e[30]});
      check("stall_imm", {7'h0, imm_sample}, {7'h0, e[31:7]});
      tick();
    end
    stall = 1'b0;
    tick();
    mem_gate = 1'b0;
    #3;
    check("skid_to_id_pc", id_pc, 32'h10);
    check("skid_to_id_valid", {31'h0, id_valid}, 32'h1);
    repeat (2) tick();

    // redirect while waiting: late response discarded
    redirect_flow(32'h100, 32'h100);

    // redirect, stall and rvalid together
    exp_req.push_back(32'h108);
    exp_req.push_back(32'h200);
    stall    = 1'b1;
    mem_gate = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    mem_gate       = 1'b0;
    #3;
    check("combo_id_valid", {31'h0, id_valid}, 32'h0);
    check("combo_pc", imem_addr, 32'h200);
    repeat (2) tick();

    // wrap from the top of the address space
    redirect_flow(32'hFFFF_FFFC, 32'hFFFF_FFFC);

    // misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    mem_gate       = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #3;
      check("trap_fault", {31'h0, fetch_fault}, 32'h1);
      check("trap_no_req", {31'h0, imem_req}, 32'h0);
      check("trap_id_valid", {31'h0, id_valid}, 32'h0);
      tick();
    end
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    push_id(32'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #3;
    check("trap_fault_cleared", {31'h0, fetch_fault}, 32'h0);
    tick();
    tick();
    mem_gate = 1'b0;
    repeat (2) tick();
`else
    redirect_flow(32'h102, 32'h100);
    check("no_trap_fault", {31'h0, fetch_fault}, 32'h0);
`endif

    // reset with a request outstanding; stale response lands in S_REQ
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_state("mid_reset");
    tick();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    push_id(32'h0);
    rst_n    = 1'b1;
    mem_gate = 1'b1;
    tick();
    tick();
    mem_gate = 1'b0;
    repeat (3) tick();

    check("req_queue_drained", exp_req.size(), 32'h0);
    check("id_queue_drained", exp_id.size(), 32'h0);
    check("wrap_req_count", w_seen.size(), 32'h2);
    if (w_seen.size() == 2) begin
      check("wrap_first_req", w_seen[0], 32'hFFFF_FFFC);
      check("wrap_second_req", w_seen[1], 32'h0);
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory request strobe, one cycle per request.
REQ-005 SHALL have port imem_addr, output, 32 bits: the fetch address, valid while imem_req=1.
REQ-006 SHALL have port imem_rvalid, input, 1 bit: response strobe.
REQ-007 SHALL have port imem_rdata, input, 32 bits: the instruction word, valid while imem_rvalid=1.
REQ-008 SHALL have port stall, input, 1 bit: hazard hold from downstream; freezes the IF/ID register.
REQ-009 SHALL have port redirect_valid, input, 1 bit: taken branch or jump.
REQ-010 SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-011 SHALL have port id_valid, output, 1 bit: the IF/ID register holds a live instruction.
REQ-012 SHALL have ports id_pc and id_instr, outputs, 32 bits each: the held PC and the held instruction.
REQ-013 SHALL have decoder-feed outputs: opcode (opcodes_t, id_instr[6:0]), func3 (3 bits, id_instr[14:12]), f7 (1 bit, id_instr[30]) and immSample (25 bits, id_instr[31:7]).
REQ-014 SHALL have port fetch_fault, output, 1 bit: misaligned-target flag (see Configuration).

Function
REQ-015 SHALL allow at most one outstanding imem request at any time.
REQ-016 SHALL implement states S_REQ, S_WAIT, S_HOLD and S_DROP, with the transitions in REQ-017 to REQ-021.
REQ-017 S_REQ: drive imem_req=1 with imem_addr=pc; then go to S_WAIT.
REQ-018 S_WAIT, rvalid with (stall=0 or id_valid=0): load the IF/ID register with {pc, rdata}, set id_valid=1, advance pc by 4, go to S_REQ.
REQ-019 S_WAIT, rvalid with stall=1 and id_valid=1: capture {pc, rdata} in a 1-entry skid buffer, advance pc by 4, go to S_HOLD, issue no request.
REQ-020 S_HOLD: on the first cycle with stall=0, move the skid buffer into IF/ID, set id_valid=1, go to S_REQ.
REQ-021 When stall=0, no new instruction is loaded and the state is not S_HOLD: clear id_valid on that edge (the entry is consumed).
REQ-022 Redirect SHALL have priority over stall and over a same-cycle rvalid: on that edge clear id_valid, empty the skid buffer and set pc=redirect_pc.
REQ-023 Redirect in S_WAIT without rvalid: go to S_DROP.
REQ-024 Redirect in any other case, or in S_WAIT with same-cycle rvalid: go to S_REQ.
REQ-025 S_DROP: discard the next rvalid, then go to S_REQ; a further redirect in S_DROP only updates pc.
REQ-026 Latency: imem_req SHALL assert in the first cycle after rst_n is released; id_valid SHALL rise on the edge that samples rvalid.
REQ-027 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 Decoder-feed fields SHALL be combinational slices of id_instr and SHALL stay stable while stall=1.

Reset
REQ-029 While rst_n=0 at a clock edge: pc=RESET_PC, state=S_REQ, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP), skid buffer empty, fetch_fault=0, imem_req=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; a stale rvalid arriving while in S_REQ SHALL be ignored.

Configuration
REQ-031 With FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault (sticky), clear id_valid and issue no requests until the next aligned redirect, which clears fetch_fault.
REQ-032 Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 2'b00 and fetch_fault SHALL be tied to 0.

Structure
REQ-033 core_types_pkg SHALL hold fetch_state_t (the four states), the if_id_t struct {valid, pc, instr} and the NOP_INSTR constant; opcodes_t SHALL be reused from that package.
REQ-034 The IF/ID register with its skid buffer SHALL be a sub-module named if_id_reg; the FSM and pc SHALL stay in fetch_stage.

Verification
REQ-035 Reset then a memory with 1-cycle latency: requests go to 0x0, 0x4, 0x8; id_pc follows the same sequence with id_valid=1.
REQ-036 stall=1 for 3 cycles with id_valid=1 and a response arriving: id_instr unchanged, no new imem_req; after release, the skid-buffer instruction appears next cycle.
REQ-037 Redirect to 0x100 while in S_WAIT: the late rvalid is dropped, the next imem_addr=0x100, and no instruction from the old path reaches id_valid.
REQ-038 Redirect, stall and rvalid in the same cycle: id_valid=0 next cycle, pc=redirect_pc.
REQ-039 RESET_PC=32'hFFFF_FFFC: the second request is to 0x0.
REQ-040 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102: fetch_fault=1 and no imem_req; a later redirect to 0x200 clears it and fetches 0x200. Without the macro, the same redirect fetches 0x100.
